// File: rtl/mat_weight_loader_if.sv
// Bundle of the loader's request handshake, data-memory read port and matrix-unit write port.
// Weight and memory words are IEEE-754 single-precision bit patterns carried as 32-bit vectors.
interface mat_weight_loader_if #(
    parameter int WIDTH              = 16,
    parameter int DATA_MEM_ADDR_SIZE = 32,
    parameter int WIDTH_ADDR_SIZE    = $clog2(WIDTH)
);
    logic                          start;
    logic                          abort;
    logic [DATA_MEM_ADDR_SIZE-1:0] base_addr;
    logic [7:0]                    stride;
    logic [WIDTH_ADDR_SIZE-1:0]    start_row;
    logic [WIDTH_ADDR_SIZE:0]      row_count;
    logic                          busy;
    logic                          done;
    logic                          err;

    logic [DATA_MEM_ADDR_SIZE-1:0] ctrl_read_addr;
    logic                          ctrl_read_grant;
    logic [DATA_MEM_ADDR_SIZE-1:0] data_mem_read_addr;
    logic [WIDTH-1:0][31:0]        data_mem_data_out;

    logic                          unit_set_weight;
    logic [WIDTH_ADDR_SIZE-1:0]    unit_set_weight_row;
    logic [WIDTH-1:0][31:0]        unit_data_in;

    modport slave (
        input  start, abort, base_addr, stride, start_row, row_count,
        input  ctrl_read_addr, data_mem_data_out,
        output busy, done, err, ctrl_read_grant, data_mem_read_addr,
        output unit_set_weight, unit_set_weight_row, unit_data_in
    );

    modport master (
        output start, abort, base_addr, stride, start_row, row_count,
        output ctrl_read_addr, data_mem_data_out,
        input  busy, done, err, ctrl_read_grant, data_mem_read_addr,
        input  unit_set_weight, unit_set_weight_row, unit_data_in
    );
endinterface

// File: rtl/mat_weight_loader.sv
// Copies a block of rows from data memory into the matrix unit's weight rows, one row per
// cycle, borrowing the data-memory read port from the controller while it runs.
module mat_weight_loader #(
    parameter int WIDTH              = 16,
    parameter int DATA_MEM_ADDR_SIZE = 32,
    parameter int WIDTH_ADDR_SIZE    = $clog2(WIDTH)
) (
    input logic                clock,
    input logic                reset,
    mat_weight_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    localparam logic [WIDTH_ADDR_SIZE+1:0] ROW_LIMIT = (WIDTH_ADDR_SIZE+2)'(WIDTH);

    state_t                        state_reg, state_next;
    logic [DATA_MEM_ADDR_SIZE-1:0] addr_reg, addr_next;
    logic [7:0]                    stride_reg, stride_next;
    logic [WIDTH_ADDR_SIZE-1:0]    row_reg, row_next;
    logic [WIDTH_ADDR_SIZE:0]      remaining_reg, remaining_next;
    logic                          strobe_reg, strobe_next;
    logic [WIDTH_ADDR_SIZE-1:0]    unit_row_reg, unit_row_next;
    logic [WIDTH-1:0][31:0]        unit_data_reg, unit_data_next;
    logic                          done_reg, done_next;
    logic                          err_reg, err_next;

    // Range check is one bit wider than row_count so start_row+row_count cannot overflow.
    logic [WIDTH_ADDR_SIZE+1:0]    req_end;
    logic                          req_invalid;

    assign req_end     = {2'b00, bus.start_row} + {1'b0, bus.row_count};
    assign req_invalid = (bus.row_count == '0) || (req_end > ROW_LIMIT);

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        stride_next    = stride_reg;
        row_next       = row_reg;
        remaining_next = remaining_reg;
        unit_row_next  = unit_row_reg;
        unit_data_next = unit_data_reg;
        strobe_next    = 1'b0;
        done_next      = 1'b0;
        err_next       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (req_invalid) begin
                        err_next = 1'b1;
                    end else begin
                        addr_next      = bus.base_addr;
                        stride_next    = bus.stride;
                        row_next       = bus.start_row;
                        remaining_next = bus.row_count;
                        state_next     = LOAD;
                    end
                end
            end
            LOAD: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else begin
                    // Row fetched this cycle is presented to the matrix unit next cycle.
                    strobe_next    = 1'b1;
                    unit_row_next  = row_reg;
                    unit_data_next = bus.data_mem_data_out;
                    addr_next      = addr_reg + DATA_MEM_ADDR_SIZE'(stride_reg);
                    row_next       = row_reg + WIDTH_ADDR_SIZE'(1);
                    remaining_next = remaining_reg - (WIDTH_ADDR_SIZE+1)'(1);
                    if (remaining_reg == (WIDTH_ADDR_SIZE+1)'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_next = IDLE;
                done_next  = !bus.abort;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            stride_reg    <= '0;
            row_reg       <= '0;
            remaining_reg <= '0;
            strobe_reg    <= 1'b0;
            unit_row_reg  <= '0;
            unit_data_reg <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            stride_reg    <= stride_next;
            row_reg       <= row_next;
            remaining_reg <= remaining_next;
            strobe_reg    <= strobe_next;
            unit_row_reg  <= unit_row_next;
            unit_data_reg <= unit_data_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    assign bus.busy                = (state_reg != IDLE);
    assign bus.ctrl_read_grant     = (state_reg == IDLE);
    assign bus.data_mem_read_addr  = (state_reg == IDLE) ? bus.ctrl_read_addr : addr_reg;
    assign bus.done                = done_reg;
    assign bus.err                 = err_reg;
    assign bus.unit_set_weight     = strobe_reg;
    assign bus.unit_set_weight_row = unit_row_reg;
    assign bus.unit_data_in        = unit_data_reg;
endmodule

// File: tb/tb_mat_weight_loader.sv
// Directed bench for mat_weight_loader: table of load requests plus hand sequences for
// abort/start collisions and reset in the middle of a load.
module tb_mat_weight_loader;
    localparam logic [31:0] CTRL_ADDR = 32'h0C0F_FEE0;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mat_weight_loader_if bus_if ();

    mat_weight_loader dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    int checks   = 0;
    int failures = 0;

    // Data memory: every word encodes its row address and lane so misplaced rows are visible.
    function automatic logic [15:0][31:0] mem_row(input logic [31:0] a);
        logic [15:0][31:0] r;
        for (int j = 0; j < 16; j++) r[j] = {a[23:0], 8'(j)};
        return r;
    endfunction

    function automatic logic [15:0][31:0] bg_row(input int row);
        logic [15:0][31:0] r;
        for (int j = 0; j < 16; j++) r[j] = {16'hBAD0, 8'(row), 8'(j)};
        return r;
    endfunction

    always_comb bus_if.data_mem_data_out = mem_row(bus_if.data_mem_read_addr);

    // Matrix-unit model and per-run observations
    logic [15:0][31:0] wmodel [16];
    int                wcount [16];
    logic [31:0]       addr_log [64];
    int err_cycle, err_cnt, done_cycle, done_cnt, nstrobe, first_strobe;
    int grant_low, grant_mismatch, busy_after_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int row_errors(input logic [31:0] base, input logic [7:0] stride,
                                      input int srow, input int nrows);
        int e;
        logic [15:0][31:0] exp;
        e = 0;
        for (int r = 0; r < 16; r++) begin
            if (r >= srow && r < srow + nrows)
                exp = mem_row(base + 32'(r - srow) * {24'b0, stride});
            else
                exp = bg_row(r);
            if (wmodel[r] !== exp) e++;
            if (wcount[r] > 1) e++;
        end
        return e;
    endfunction

    // Caller is positioned just after a falling edge; request is sampled at the next rising edge.
    task automatic run_req(input logic [31:0] base, input logic [7:0] stride, input logic [3:0] srow,
                           input logic [4:0] cnt, input int abort_after, input int inject_cycle,
                           input int ncycles);
        bit abort_issued;
        abort_issued = 0;
        for (int r = 0; r < 16; r++) begin
            wmodel[r] = bg_row(r);
            wcount[r] = 0;
        end
        for (int i = 0; i < 64; i++) addr_log[i] = 'x;
        err_cycle = -1; err_cnt = 0; done_cycle = -1; done_cnt = 0;
        nstrobe = 0; first_strobe = -1; grant_low = 0; grant_mismatch = 0; busy_after_done = 0;
        bus_if.base_addr = base;
        bus_if.stride    = stride;
        bus_if.start_row = srow;
        bus_if.row_count = cnt;
        bus_if.start     = 1'b1;
        bus_if.abort     = 1'b0;
        @(posedge clock);
        for (int c = 1; c <= ncycles; c++) begin
            @(negedge clock);
            bus_if.start = 1'b0;
            bus_if.abort = 1'b0;
            if (c == inject_cycle) begin
                bus_if.base_addr = 32'd900;
                bus_if.stride    = 8'd8;
                bus_if.start_row = 4'd8;
                bus_if.row_count = 5'd8;
                bus_if.start     = 1'b1;
            end
            if (c < 64) addr_log[c] = bus_if.data_mem_read_addr;
            if (bus_if.unit_set_weight) begin
                wmodel[bus_if.unit_set_weight_row] = bus_if.unit_data_in;
                wcount[bus_if.unit_set_weight_row]++;
                nstrobe++;
                if (first_strobe < 0) first_strobe = c;
            end
            if (!bus_if.ctrl_read_grant) grant_low++;
            if (bus_if.busy == bus_if.ctrl_read_grant) grant_mismatch++;
            if (bus_if.ctrl_read_grant && bus_if.data_mem_read_addr !== CTRL_ADDR) grant_mismatch++;
            if (done_cycle > 0 && bus_if.busy) busy_after_done++;
            if (bus_if.done) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (bus_if.err) begin
                err_cnt++;
                if (err_cycle < 0) err_cycle = c;
            end
            if (abort_after > 0 && nstrobe == abort_after && !abort_issued) begin
                bus_if.abort = 1'b1;
                abort_issued = 1;
            end
        end
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
    endtask

    typedef struct {
        logic [31:0] base;
        logic [7:0]  stride;
        logic [3:0]  srow;
        logic [4:0]  cnt;
        int          abort_after;
        int          exp_err;
        int          exp_done;
        int          exp_rows;
        int          exp_grant_low;
        logic [31:0] exp_addr0;
        logic [31:0] exp_addr1;
        logic [31:0] exp_addr_last;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int busy_seen, err_seen;
        vecs[0] = '{32'd100,        8'd1,   4'd0,  5'd16, 0, -1, 18, 16, 17, 32'd100,        32'd101,        32'd115};
        vecs[1] = '{32'd8,          8'd4,   4'd12, 5'd4,  0, -1,  6,  4,  5, 32'd8,          32'd12,         32'd20};
        vecs[2] = '{32'd0,          8'd1,   4'd0,  5'd0,  0,  1, -1,  0,  0, 32'd0,          32'd0,          32'd0};
        vecs[3] = '{32'd40,         8'd1,   4'd10, 5'd7,  0,  1, -1,  0,  0, 32'd0,          32'd0,          32'd0};
        vecs[4] = '{32'hFFFF_FFFE,  8'd1,   4'd0,  5'd4,  0, -1,  6,  4,  5, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'h0000_0001};
        vecs[5] = '{32'd77,         8'd3,   4'd15, 5'd1,  0, -1,  3,  1,  2, 32'd77,         32'd0,          32'd77};
        vecs[6] = '{32'd1000,       8'd255, 4'd10, 5'd6,  0, -1,  8,  6,  7, 32'd1000,       32'd1255,       32'd2275};
        vecs[7] = '{32'd50,         8'd2,   4'd0,  5'd8,  3, -1, -1,  3,  4, 32'd50,         32'd52,         32'd0};
        vecs[8] = '{32'd5,          8'd1,   4'd0,  5'd17, 0,  1, -1,  0,  0, 32'd0,          32'd0,          32'd0};

        bus_if.start = 0; bus_if.abort = 0; bus_if.base_addr = 0; bus_if.stride = 0;
        bus_if.start_row = 0; bus_if.row_count = 0; bus_if.ctrl_read_addr = CTRL_ADDR;

        // Reset state
        #12;
        check("rst_busy",   32'(bus_if.busy), 0);
        check("rst_done",   32'(bus_if.done), 0);
        check("rst_err",    32'(bus_if.err), 0);
        check("rst_strobe", 32'(bus_if.unit_set_weight), 0);
        check("rst_row",    32'(bus_if.unit_set_weight_row), 0);
        check("rst_data",   32'(bus_if.unit_data_in != '0), 0);
        check("rst_grant",  32'(bus_if.ctrl_read_grant), 1);
        check("rst_addr",   bus_if.data_mem_read_addr, CTRL_ADDR);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        for (int v = 0; v < 9; v++) begin
            run_req(vecs[v].base, vecs[v].stride, vecs[v].srow, vecs[v].cnt,
                    vecs[v].abort_after, 0, int'(vecs[v].cnt) + 6);
            $display("vec %0d base=%h stride=%0d start_row=%0d count=%0d strobes=%0d done@%0d err@%0d",
                     v, vecs[v].base, vecs[v].stride, vecs[v].srow, vecs[v].cnt,
                     nstrobe, done_cycle, err_cycle);
            check($sformatf("v%0d_err_cycle", v),  err_cycle, vecs[v].exp_err);
            check($sformatf("v%0d_err_cnt", v),    err_cnt, (vecs[v].exp_err > 0) ? 1 : 0);
            check($sformatf("v%0d_done_cycle", v), done_cycle, vecs[v].exp_done);
            check($sformatf("v%0d_done_cnt", v),   done_cnt, (vecs[v].exp_done > 0) ? 1 : 0);
            check($sformatf("v%0d_strobes", v),    nstrobe, vecs[v].exp_rows);
            check($sformatf("v%0d_first_strobe", v), first_strobe, (vecs[v].exp_rows > 0) ? 2 : -1);
            check($sformatf("v%0d_grant_low", v),  grant_low, vecs[v].exp_grant_low);
            check($sformatf("v%0d_grant_mux", v),  grant_mismatch, 0);
            check($sformatf("v%0d_rows", v),
                  row_errors(vecs[v].base, vecs[v].stride, int'(vecs[v].srow), vecs[v].exp_rows), 0);
            if (vecs[v].exp_rows > 0) begin
                check($sformatf("v%0d_addr0", v), addr_log[1], vecs[v].exp_addr0);
                check($sformatf("v%0d_row_hold", v), 32'(bus_if.unit_set_weight_row),
                      32'(int'(vecs[v].srow) + vecs[v].exp_rows - 1));
            end
            if (vecs[v].exp_rows > 1)
                check($sformatf("v%0d_addr1", v), addr_log[2], vecs[v].exp_addr1);
            if (vecs[v].exp_done > 0)
                check($sformatf("v%0d_addr_last", v), addr_log[vecs[v].cnt], vecs[v].exp_addr_last);
        end

        // start and abort together in IDLE: abort wins, for valid and invalid requests
        for (int t = 0; t < 2; t++) begin
            bus_if.base_addr = 32'd5; bus_if.stride = 8'd1; bus_if.start_row = 4'd0;
            bus_if.row_count = (t == 0) ? 5'd4 : 5'd0;
            bus_if.start = 1'b1; bus_if.abort = 1'b1;
            busy_seen = 0; err_seen = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clock);
                bus_if.start = 1'b0; bus_if.abort = 1'b0;
                if (bus_if.busy || bus_if.unit_set_weight) busy_seen++;
                if (bus_if.err) err_seen++;
            end
            $display("start+abort test %0d busy_cycles=%0d err_cycles=%0d", t, busy_seen, err_seen);
            check($sformatf("sa%0d_busy", t), busy_seen, 0);
            check($sformatf("sa%0d_err", t), err_seen, 0);
        end

        // Reset during LOAD, then a start issued while busy must be ignored
        bus_if.base_addr = 32'd200; bus_if.stride = 8'd1; bus_if.start_row = 4'd0;
        bus_if.row_count = 5'd16; bus_if.start = 1'b1;
        @(negedge clock);
        bus_if.start = 1'b0;
        repeat (3) @(negedge clock);
        check("mid_strobe", 32'(bus_if.unit_set_weight), 1);
        check("mid_grant",  32'(bus_if.ctrl_read_grant), 0);
        #2 reset = 1'b0;
        #1;
        $display("reset mid-load strobe=%0b busy=%0b grant=%0b row=%0d",
                 bus_if.unit_set_weight, bus_if.busy, bus_if.ctrl_read_grant, bus_if.unit_set_weight_row);
        check("arst_strobe", 32'(bus_if.unit_set_weight), 0);
        check("arst_busy",   32'(bus_if.busy), 0);
        check("arst_grant",  32'(bus_if.ctrl_read_grant), 1);
        check("arst_addr",   bus_if.data_mem_read_addr, CTRL_ADDR);
        check("arst_row",    32'(bus_if.unit_set_weight_row), 0);
        check("arst_data",   32'(bus_if.unit_data_in != '0), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        run_req(32'd300, 8'd1, 4'd0, 5'd8, 0, 3, 20);
        $display("post-reset load strobes=%0d done@%0d busy_after_done=%0d", nstrobe, done_cycle, busy_after_done);
        check("pr_done_cycle", done_cycle, 10);
        check("pr_done_cnt",   done_cnt, 1);
        check("pr_strobes",    nstrobe, 8);
        check("pr_rows",       row_errors(32'd300, 8'd1, 0, 8), 0);
        check("pr_no_reissue", busy_after_done, 0);
        check("pr_err",        err_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mat_weight_loader.md
MAT_WEIGHT_LOADER -- requirements
Module: mat_weight_loader

Interface
REQ-001 Parameter WIDTH, default 16: systolic array width; rows per weight matrix.
REQ-002 Parameter DATA_MEM_ADDR_SIZE, default 32: data memory address width.
REQ-003 Parameter WIDTH_ADDR_SIZE, default $clog2(WIDTH): row index width.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  load request; sampled only in IDLE.
REQ-007 abort  in  1  cancels an in-progress load.
REQ-008 base_addr  in  DATA_MEM_ADDR_SIZE  data memory address of the first source row.
REQ-009 stride  in  8  address increment between source rows; unsigned.
REQ-010 start_row  in  WIDTH_ADDR_SIZE  first destination weight row.
REQ-011 row_count  in  WIDTH_ADDR_SIZE+1  number of rows to load.
REQ-012 busy  out  1  high in LOAD and DRAIN.
REQ-013 done  out  1  one-cycle pulse on successful completion.
REQ-014 err  out  1  one-cycle pulse on a rejected request.
REQ-015 ctrl_read_addr  in  DATA_MEM_ADDR_SIZE  controller's data memory read address.
REQ-016 ctrl_read_grant  out  1  high when the controller owns the data memory read port.
REQ-017 data_mem_read_addr  out  DATA_MEM_ADDR_SIZE  address to the data memory read port.
REQ-018 data_mem_data_out  in  WIDTH x shortreal  combinational read data from data memory.
REQ-019 unit_set_weight  out  1  weight write strobe to the matrix unit.
REQ-020 unit_set_weight_row  out  WIDTH_ADDR_SIZE  destination weight row.
REQ-021 unit_data_in  out  WIDTH x shortreal  weight row data.

Function
REQ-022 The block SHALL implement the states IDLE, LOAD and DRAIN.
REQ-023 In IDLE, ctrl_read_grant SHALL be 1 and data_mem_read_addr SHALL equal ctrl_read_addr, combinationally.
REQ-024 In LOAD and DRAIN, ctrl_read_grant SHALL be 0 and the loader SHALL drive data_mem_read_addr.
REQ-025 IDLE with start=1, abort=0 and a valid request SHALL latch all request inputs and enter LOAD on the next edge.
REQ-026 A request is invalid if row_count==0 or start_row+row_count>WIDTH, computed at WIDTH_ADDR_SIZE+2 bits.
REQ-027 An invalid request SHALL pulse err for one cycle, starting the next cycle, and the block SHALL stay in IDLE.
REQ-028 LOAD, cycle k (k=0..N-1), SHALL drive data_mem_read_addr = base + k*stride, truncated modulo 2^DATA_MEM_ADDR_SIZE, and SHALL register data_mem_data_out.
REQ-029 The cycle after each LOAD cycle k SHALL assert unit_set_weight=1, unit_set_weight_row=start_row+k and unit_data_in = the data registered in cycle k.
REQ-030 After LOAD cycle N-1 the block SHALL enter DRAIN; DRAIN SHALL last one cycle and carry the final strobe.
REQ-031 DRAIN SHALL be followed by IDLE, with done=1 for exactly that first IDLE cycle.
REQ-032 unit_set_weight SHALL be 0 in all other cycles; unit_data_in and unit_set_weight_row SHALL hold their last values.
REQ-033 start while busy SHALL be ignored.
REQ-034 Timing: start accepted at edge 0; strobes on cycles 2..N+1; done on cycle N+2.
REQ-035 abort in LOAD or DRAIN SHALL return the block to IDLE on the next edge, with unit_set_weight=0 from that edge, no done and no err.
REQ-036 abort and start together in IDLE: abort wins; no load starts and no err is raised.
REQ-037 A row already written before an abort SHALL NOT be rewritten.

Reset
REQ-038 reset=0 SHALL asynchronously force IDLE, busy=0, done=0, err=0, unit_set_weight=0, unit_set_weight_row=0, and unit_data_in all 0.0.
REQ-039 Reset during LOAD SHALL drop unit_set_weight immediately, and the port SHALL return to the controller.
REQ-040 After reset release, the first start SHALL be sampled on the first rising edge with reset=1.

Verification
REQ-041 Full load: base=100, stride=1, start_row=0, count=16 -> rows 0..15 get mem[100..115]; strobes on cycles 2..17; done on cycle 18; grant=0 during cycles 1..17.
REQ-042 Strided partial load: base=8, stride=4, start_row=12, count=4 -> rows 12..15 get mem[8], mem[12], mem[16], mem[20]; rows 0..11 are unchanged.
REQ-043 Invalid requests: count=0, and start_row=10 with count=7 -> err pulse, busy stays 0, no strobe, grant stays 1.
REQ-044 Abort after the third strobe: count=8 -> exactly rows 0..2 are written, no done, and grant=1 on the next cycle.
REQ-045 Address wrap: base=2^32-2, stride=1, count=4 -> addresses FFFFFFFE, FFFFFFFF, 0, 1.
REQ-046 Reset asserted mid-LOAD, then start during busy -> reset values appear immediately; a start issued while busy is ignored and its request is never executed.
